// File: rtl/mode_counter_pkg.sv
// Shared constants for the mode_counter block: boundary-mode and direction encodings.
package mode_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

endpackage

// File: rtl/mode_counter_prescaler.sv
// Prescaler for mode_counter: emits tick once every prescale+1 enabled cycles.
module count_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [PRESCALE_W-1:0] pre_cnt_d;

  // >= rather than == so lowering prescale mid-interval ticks on the next enabled cycle
  assign tick = (pre_cnt_q >= prescale);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (restart) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with wrap or saturate boundary mode, clear/load and terminal-count pulse.
// Optional prescaler enabled by defining MODE_COUNTER_PRESCALE_EN.
module mode_counter #(
  parameter int WIDTH      = 8,
  parameter int MAX_VAL    = 2**WIDTH-1,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  mode,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  zero
);

  import mode_counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic             tick;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

`ifdef MODE_COUNTER_PRESCALE_EN
  count_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .restart  (clear | load),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign tick = 1'b1;
`endif

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en && tick) begin
      if (up == DIR_UP) begin
        if (count_q < MAX_V) begin
          count_d = count_q + 1'b1;
          tc_d    = (mode == MODE_SAT) && (count_q == MAX_V - 1'b1);
        end else begin
          count_d = (mode == MODE_WRAP) ? '0 : MAX_V;
          tc_d    = (mode == MODE_WRAP);
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
          tc_d    = (mode == MODE_SAT) && (count_q == {{(WIDTH-1){1'b0}}, 1'b1});
        end else begin
          count_d = (mode == MODE_WRAP) ? MAX_V : '0;
          tc_d    = (mode == MODE_WRAP);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter (WIDTH=8, MAX_VAL=9) with a behavioural reference model.
module tb_mode_counter;

  localparam int WIDTH = 8;
  localparam int MAXV  = 9;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0, up = 1'b1, mode = 1'b0, clear = 1'b0, load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [PW-1:0]    prescale = '0;
  logic [WIDTH-1:0] count;
  logic             tc, zero;

  mode_counter #(.WIDTH(WIDTH), .MAX_VAL(MAXV), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .mode(mode), .clear(clear),
    .load(load), .load_val(load_val), .prescale(prescale),
    .count(count), .tc(tc), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int tc;
    int zero;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference state
  int m_cnt = 0;
  int m_pre = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock of stimulus: drive at negedge, predict the post-edge outputs, queue them.
  task automatic cycle(input string tag, input bit e, input bit u, input bit md,
                       input bit cl, input bit ld, input int lv, input int ps);
    exp_t x;
    bit   tick;
    int   t;
    @(negedge clk);
    en = e; up = u; mode = md; clear = cl; load = ld;
    load_val = lv[WIDTH-1:0]; prescale = ps[PW-1:0];
`ifdef MODE_COUNTER_PRESCALE_EN
    tick = (m_pre >= ps);
`else
    tick = 1'b1;
`endif
    t = 0;
    if (cl) begin
      m_cnt = 0; m_pre = 0;
    end else if (ld) begin
      m_cnt = (lv > MAXV) ? MAXV : lv; m_pre = 0;
    end else if (e) begin
      if (!tick) begin
        m_pre = m_pre + 1;
      end else begin
        m_pre = 0;
        if (u) begin
          if (m_cnt == MAXV) begin
            m_cnt = md ? MAXV : 0;
            t = md ? 0 : 1;
          end else begin
            m_cnt = m_cnt + 1;
            t = (md && m_cnt == MAXV) ? 1 : 0;
          end
        end else begin
          if (m_cnt == 0) begin
            m_cnt = md ? 0 : MAXV;
            t = md ? 0 : 1;
          end else begin
            m_cnt = m_cnt - 1;
            t = (md && m_cnt == 0) ? 1 : 0;
          end
        end
      end
    end
    x.cnt = m_cnt; x.tc = t; x.zero = (m_cnt == 0) ? 1 : 0; x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, up, mode, 1'b0, 1'b0, 0, prescale);
  endtask

  // Monitor: every cycle the counter presents a registered result; compare against the queue head.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk({x.tag, ".count"}, int'(count), x.cnt);
        chk({x.tag, ".tc"},    int'(tc),    x.tc);
        chk({x.tag, ".zero"},  int'(zero),  x.zero);
        $display("txn %s count=%0d tc=%0d zero=%0d", x.tag, count, tc, zero);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst.count", int'(count), 0);
    chk("rst.tc",    int'(tc),    0);
    chk("rst.zero",  int'(zero),  1);
    @(negedge clk);
    rst_n = 1'b1;

    // count 1..9 then wrap to 0 with a single tc pulse
    for (int i = 0; i < 10; i++) cycle("wrap_up", 1, 1, 0, 0, 0, 0, 0);
    // saturate down from 3
    cycle("sat_load3", 0, 0, 1, 0, 1, 3, 0);
    for (int i = 0; i < 5; i++) cycle("sat_down", 1, 0, 1, 0, 0, 0, 0);
    // prescale=2 with a frozen gap mid-interval
    cycle("ps_clear", 0, 1, 0, 1, 0, 0, 2);
    for (int i = 0; i < 7; i++) cycle("ps2_up", 1, 1, 0, 0, 0, 0, 2);
    for (int i = 0; i < 5; i++) cycle("ps2_freeze", 0, 1, 0, 0, 0, 0, 2);
    for (int i = 0; i < 6; i++) cycle("ps2_resume", 1, 1, 0, 0, 0, 0, 2);
    // lower prescale below pre_cnt mid-interval
    for (int i = 0; i < 2; i++) cycle("ps_hi", 1, 1, 0, 0, 0, 0, 7);
    cycle("ps_lower", 1, 1, 0, 0, 0, 0, 0);
    // clear beats load; then clamped load
    cycle("clr_ld", 1, 1, 0, 1, 1, 7, 0);
    cycle("ld_clamp", 1, 1, 0, 0, 1, 200, 0);
    cycle("ld_hold", 0, 1, 0, 0, 0, 0, 0);

    // async reset mid-count and mid-interval
    cycle("pre_rst_ld5", 0, 1, 0, 0, 1, 5, 2);
    cycle("pre_rst_en", 1, 1, 0, 0, 0, 0, 2);
    @(negedge clk);
    en = 1'b0; clear = 1'b0; load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.count", int'(count), 0);
    chk("midrst.tc",    int'(tc),    0);
    chk("midrst.zero",  int'(zero),  1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0; m_pre = 0;
    for (int i = 0; i < 4; i++) cycle("post_rst", 1, 1, 0, 0, 0, 0, 2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cycle("rand", ($urandom_range(0, 9) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            (r < 3), (r >= 3 && r < 8), $urandom_range(0, 255), $urandom_range(0, 3));
    end
    idle("tail", 1);

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
